// File: rtl/sum_seq_stream.sv
// sum_seq_stream: accumulates N_OPS unsigned operands per block from a valid/ready stream and emits the sum.
// Define SUM_SEQ_AVG_EN to add the truncated-mean output out_avg.
module sum_seq_stream #(
  parameter int N_OPS = 8,
  parameter int W_IN  = 4,
  parameter int W_SUM = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_IN-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W_SUM-1:0]        out_sum,
`ifdef SUM_SEQ_AVG_EN
  output logic [W_IN-1:0]         out_avg,
`endif
  output logic [$clog2(N_OPS):0]  op_cnt
);
  localparam int LG = $clog2(N_OPS);
  localparam logic [LG:0] LAST = (LG+1)'(N_OPS - 1);
  typedef enum logic {ACC, DONE} state_t;
  state_t state, state_nxt;
  logic live, in_beat, last;
  logic [W_SUM-1:0] acc, sum;
  assign in_beat = in_valid && in_ready;
  assign last = op_cnt == LAST;
  assign sum = acc + W_SUM'(in_data);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else state <= state_nxt;
  always_comb
    state_nxt = clr ? ACC
              : (in_beat && last) ? DONE
              : (state == DONE && out_ready) ? ACC
              : state;
  // live holds in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = state == ACC && live;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      live    <= 1'b0;
      acc     <= '0;
      op_cnt  <= '0;
      out_sum <= '0;
`ifdef SUM_SEQ_AVG_EN
      out_avg <= '0;
`endif
    end else begin
      live <= 1'b1;
      if (clr) begin
        acc    <= '0;
        op_cnt <= '0;
      end else if (in_beat) begin
        acc    <= last ? '0 : sum;
        op_cnt <= last ? '0 : op_cnt + 1'b1;
        if (last) out_sum <= sum;
`ifdef SUM_SEQ_AVG_EN
        if (last) out_avg <= sum[W_SUM-1:LG];
`endif
      end
    end
endmodule

// File: tb/tb_sum_seq_stream.sv
// tb_sum_seq_stream: table-driven, hand-written and randomized checks of sum_seq_stream against a summing model.
module tb_sum_seq_stream;
  logic clk, rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_data;
  logic [6:0] out_sum;
  logic [3:0] out_avg;
  logic [3:0] op_cnt;
  int vecs = 0, errs = 0;

  sum_seq_stream dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef SUM_SEQ_AVG_EN
    .out_avg(out_avg),
`endif
    .op_cnt(op_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0][3:0] ops;
    bit gaps;
    int sum;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] d);
    int n = 0;
    in_valid = 1;
    in_data = d;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    if (n == 50) chk("in_ready_timeout", 0, 1);
    tick;
    in_valid = 0;
    in_data = 'x;
  endtask

  task automatic run_block(input logic [7:0][3:0] ops, input bit gaps, input int exp);
    for (int i = 0; i < 8; i++) begin
      beat(ops[i]);
      chk("op_cnt", op_cnt, (i == 7) ? 0 : i + 1);
      if (gaps && i < 7) begin
        tick;
        tick;
        chk("op_cnt_gap", op_cnt, i + 1);
      end
    end
    chk("out_valid_done", out_valid, 1);
    chk("out_sum", out_sum, exp);
    chk("in_ready_done", in_ready, 0);
`ifdef SUM_SEQ_AVG_EN
    chk("out_avg", out_avg, exp / 8);
`endif
  endtask

  task automatic drain(input int w, input int exp);
    repeat (w) begin
      tick;
      chk("out_valid_hold", out_valid, 1);
      chk("out_sum_hold", out_sum, exp);
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("out_sum_keep", out_sum, exp);
  endtask

  initial begin
    logic [7:0][3:0] ops;
    int exp;
    bit g;
    tbl[0] = '{ops: {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, gaps: 0, sum: 36};
    tbl[1] = '{ops: {8{4'd15}}, gaps: 0, sum: 120};
    tbl[2] = '{ops: {8{4'd0}}, gaps: 0, sum: 0};
    tbl[3] = '{ops: {8{4'd3}}, gaps: 1, sum: 24};
    rst_n = 0; clr = 0; in_valid = 0; in_data = 'x; out_ready = 0;
    #3;
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_in_ready", in_ready, 0);
    tick; tick;
    rst_n = 1;
    chk("in_ready_pre", in_ready, 0);
    tick;
    chk("in_ready_post", in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      run_block(tbl[i].ops, tbl[i].gaps, tbl[i].sum);
      drain(0, tbl[i].sum);
    end

    // consumer stalls five cycles while a producer keeps offering data
    run_block(tbl[0].ops, 0, 36);
    in_valid = 1;
    in_data = 4'd5;
    repeat (5) begin
      tick;
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", out_sum, 36);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_op_cnt", op_cnt, 0);
    end
    in_valid = 0;
    drain(0, 36);

    // clr discards a partial block, including a coincident beat
    repeat (5) beat(4'd7);
    chk("clr_pre_cnt", op_cnt, 5);
    clr = 1; in_valid = 1; in_data = 4'd7;
    tick;
    clr = 0; in_valid = 0;
    chk("clr_cnt", op_cnt, 0);
    chk("clr_valid", out_valid, 0);
    run_block({8{4'd1}}, 0, 8);
    drain(1, 8);

    // clr during DONE drops the pending sum
    run_block({8{4'd2}}, 0, 16);
    clr = 1;
    tick;
    clr = 0;
    chk("clr_done_valid", out_valid, 0);
    chk("clr_done_ready", in_ready, 1);

    // asynchronous reset mid-block
    repeat (3) beat(4'd2);
    chk("rst_mid_pre", op_cnt, 3);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_cnt", op_cnt, 0);
    chk("rst_mid_sum", out_sum, 0);
    chk("rst_mid_ready", in_ready, 0);
    tick;
    rst_n = 1;
    tick;
    // asynchronous reset mid-DONE
    run_block(tbl[0].ops, 0, 36);
    #2 rst_n = 0;
    #1;
    chk("rst_done_valid", out_valid, 0);
    chk("rst_done_sum", out_sum, 0);
    chk("rst_done_cnt", op_cnt, 0);
    tick;
    rst_n = 1;
    tick;
    run_block({8{4'd2}}, 0, 16);
    drain(0, 16);

    // randomized blocks against a plain-sum model
    for (int r = 0; r < 24; r++) begin
      exp = 0;
      for (int k = 0; k < 8; k++) begin
        ops[k] = 4'($urandom_range(0, 15));
        exp += int'(ops[k]);
      end
      g = 1'($urandom_range(0, 1));
      run_block(ops, g, exp);
      drain(int'($urandom_range(0, 3)), exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/sum_seq_stream.md
Name: sum_seq_stream

Overview:
- Streaming, sequential counterpart to the team's combinational eight-operand adder.
- Consumes 4-bit operands one per accepted beat on a valid/ready input stream.
- Accumulates a block of N_OPS operands and presents the full-precision sum on a valid/ready output stream.
- Sits downstream of operand producers that cannot present all operands in parallel; trades width for latency.

Parameters:
- N_OPS, 8, operands per block (power of two, 2..64).
- W_IN, 4, operand width in bits.
- W_SUM, 7, sum width; must equal W_IN + log2(N_OPS), so no overflow is possible.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous abort; discards the partial block.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_data  input  W_IN  unsigned operand.
- out_valid  output  1  sum available.
- out_ready  input  1  consumer takes the sum.
- out_sum  output  W_SUM  unsigned block sum.
- op_cnt  output  log2(N_OPS)+1  operands accepted in the current block.

Behaviour:
- Reset (rst_n low, asynchronous): state=ACC, acc=0, op_cnt=0, out_valid=0, out_sum=0. in_ready rises in the first cycle after rst_n deasserts.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1, out_sum held stable.
- Beat rule: a transfer occurs on a rising edge with valid&ready high. No transfer otherwise; gaps in in_valid are allowed and ignored.
- ACC, input beat, op_cnt<N_OPS-1: acc<=acc+in_data (zero-extended to W_SUM); op_cnt<=op_cnt+1.
- ACC, input beat, op_cnt==N_OPS-1:
  - out_sum<=acc+in_data and out_valid<=1 (registered).
  - acc<=0, op_cnt<=0, state<=DONE.
  - Latency: out_valid is seen in the cycle after the last operand beat.
- DONE:
  - Holds while out_ready=0, with out_sum and out_valid stable; no operand accepted.
  - On out_valid&out_ready: state<=ACC, out_valid<=0; in_ready=1 next cycle.
  - An output beat and an input beat never coincide.
- Arithmetic: unsigned, W_SUM bits. The maximum sum N_OPS*(2^W_IN-1) fits exactly (120 for the defaults). No wrap-around.
- clr (synchronous, any state, highest priority over beats):
  - acc=0, op_cnt=0, out_valid=0, state=ACC.
  - A pending sum in DONE is dropped.
  - An input beat coincident with clr is discarded.
- in_data is ignored when in_valid=0.
- X on in_data without in_valid must not affect acc.
- out_sum keeps its last value after the output beat until the next block completes.

Optional Feature:
- Macro SUM_SEQ_AVG_EN.
- Defined: adds output out_avg (W_IN bits) = out_sum >> log2(N_OPS), i.e. truncated mean. Registered in the same cycle as out_sum, valid under out_valid, reset to 0.
- Undefined: port out_avg and its register are absent; all other behaviour is identical.

Test Plan:
- Operands 1,2,...,8 on consecutive cycles with out_ready=1 -> out_valid one cycle after the 8th beat; out_sum=36; with SUM_SEQ_AVG_EN, out_avg=4.
- Eight operands of 15 -> out_sum=120 (0x78), no wrap; out_avg=15. A following block of eight 0s -> out_sum=0, confirming acc is cleared.
- Block completes with out_ready=0 for 5 cycles:
  - out_valid and out_sum=36 held, in_ready=0, in_valid ignored.
  - out_ready=1 -> out_valid drops; in_ready=1 next cycle.
- in_valid toggled 1,0,0,1,... across 8 operands of value 3 -> out_sum=24; op_cnt increments only on beats.
- clr after 5 operands of 7, then 8 operands of 1 -> out_sum=8.
  - clr asserted during DONE drops the pending sum: out_valid=0 next cycle.
- rst_n pulsed low mid-block (after 3 beats) and mid-DONE -> outputs 0 immediately (asynchronously). The next full block of 2s -> out_sum=16.
